// File: rtl/periph_pkg.sv
// Shared owner encodings, peripheral register map and bus-request bundle for the peripheral bus.
package periph_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;
  localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/periph_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one that was not served last.
// Purely combinational; valid is low when nobody requests.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  always_comb begin
    valid = |req;
    pick  = req[1];
    if (&req) pick = ~last;
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter: round-robin with bounded locked bursts, optional idle park on M0.
// Owner gets zero-wait access; a non-owner is granted on the next cycle at earliest.
module periph_bus_arbiter
  import periph_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter bit PARK_M0  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        p_rd,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata
);

  localparam int            HW         = $clog2(MAX_HOLD + 1);
  localparam logic [1:0]    IDLE_OWNER = PARK_M0 ? OWN_M0 : OWN_NONE;
  localparam logic [HW-1:0] HOLD_SAT   = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIM   = HW'(MAX_HOLD - 1);

  logic [1:0]    owner, owner_nxt;
  logic          last, last_nxt, last_eff;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          own_req, own_lock, oth_req, keep;
  logic          pick, pick_vld;
  bus_req_t      m0_bus, m1_bus, sel_bus;

  assign m0_bus = '{rd: m0_rd, wr: m0_wr, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus = '{rd: m1_rd, wr: m1_wr, addr: m1_addr, wdata: m1_wdata};

  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    case (owner)
      OWN_M0: begin own_req = m0_req; own_lock = m0_lock; oth_req = m1_req; end
      OWN_M1: begin own_req = m1_req; own_lock = m1_lock; oth_req = m0_req; end
      default: ;
    endcase
  end

  // An owner served this cycle is the most recent grantee, so a waiting peer wins the next tie.
  assign last_eff = own_req ? (owner == OWN_M1) : last;
  assign keep     = own_req & own_lock & (~oth_req | (hold_cnt < HOLD_LIM));

  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_eff),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= IDLE_OWNER;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    owner_nxt = owner;
    last_nxt  = last_eff;
    hold_nxt  = '0;
    if (keep) begin
      if (oth_req) hold_nxt = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
    end else if (pick_vld) begin
      owner_nxt = pick ? OWN_M1 : OWN_M0;
      last_nxt  = pick;
    end else begin
      owner_nxt = IDLE_OWNER;
      if (PARK_M0) last_nxt = 1'b0;
    end
  end

  always_comb begin
    sel_bus  = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (!reset && own_req) begin
      if (owner == OWN_M1) begin
        sel_bus  = m1_bus;
        m1_ack   = 1'b1;
        m1_rdata = p_rdata;
      end else begin
        sel_bus  = m0_bus;
        m0_ack   = 1'b1;
        m0_rdata = p_rdata;
      end
    end
  end

  assign p_rd    = sel_bus.rd;
  assign p_wr    = sel_bus.wr;
  assign p_addr  = sel_bus.addr;
  assign p_wdata = sel_bus.wdata;
  assign m0_gnt  = (owner == OWN_M0);
  assign m1_gnt  = (owner == OWN_M1);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios plus random traffic against an in-bench reference model.
module tb_periph_bus_arbiter;
  import periph_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam bit PARK     = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_lock, m1_lock, m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, p_rd, p_wr;
  logic [31:0] m0_rdata, m1_rdata, p_addr, p_wdata, p_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  periph_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .PARK_M0(PARK)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m1_rd(m1_rd), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata)
  );

  // Peripheral register window: SWITCH read-only, RXD cleared by a read.
  logic [31:0] regs [0:8];
  int wr_count = 0;
  int rxd_reads = 0;

  function automatic logic [31:0] reg_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_TH;
    if (a >= ADDR_TH && a <= ADDR_UART_CON && a[1:0] == 2'b00) return regs[off[5:2]];
    return 32'h0;
  endfunction

  assign p_rdata = p_rd ? reg_rd(p_addr) : 32'h0;

  always @(posedge clk) begin : periph
    logic [31:0] off;
    off = p_addr - ADDR_TH;
    if (reset) begin
      for (int i = 0; i < 9; i++) regs[i] <= 32'h0;
      regs[4] <= 32'h0000_00A5;
      regs[7] <= 32'h0000_0055;
    end else begin
      if (p_wr && p_addr >= ADDR_TH && p_addr <= ADDR_UART_CON && p_addr != ADDR_SWITCH) begin
        regs[off[5:2]] <= p_wdata;
        wr_count <= wr_count + 1;
      end
      if (p_rd && p_addr == ADDR_UART_RXD) begin
        regs[7] <= 32'h0;
        rxd_reads <= rxd_reads + 1;
      end
    end
  end

  // Reference model: mo = 0 none / 1 M0 / 2 M1, ml = index of last served master,
  // streak = opposed locked accesses granted so far in the current tenure.
  int mo = 0, ml = 1, streak = 0;
  bit started = 1'b0;

  always @(posedge clk) begin : model
    bit rq [2];
    bit lk [2];
    bit kept;
    int k, nxt;
    rq[0] = m0_req; rq[1] = m1_req;
    lk[0] = m0_lock; lk[1] = m1_lock;
    started = 1'b1;
    if (reset) begin
      mo = PARK ? 1 : 0;
      ml = 1;
      streak = 0;
    end else begin
      kept = 1'b0;
      if (mo != 0) begin
        k = mo - 1;
        if (rq[k]) begin
          ml = k;
          if (lk[k] && (!rq[1-k] || streak + 1 < MAX_HOLD)) begin
            kept = 1'b1;
            streak = rq[1-k] ? streak + 1 : 0;
          end
        end
      end
      if (!kept) begin
        streak = 0;
        if (rq[0] && rq[1]) nxt = (ml == 0) ? 2 : 1;
        else if (rq[0])     nxt = 1;
        else if (rq[1])     nxt = 2;
        else                nxt = PARK ? 1 : 0;
        if (nxt != 0) ml = nxt - 1;
        mo = nxt;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int srv;
    logic e_rd, e_wr;
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    if (started) begin
      srv = 0;
      if (!reset && mo == 1 && m0_req) srv = 1;
      if (!reset && mo == 2 && m1_req) srv = 2;
      e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_rd0 = 0; e_rd1 = 0;
      if (srv == 1) begin
        e_rd = m0_rd; e_wr = m0_wr; e_addr = m0_addr; e_wdata = m0_wdata;
        e_rd0 = m0_rd ? reg_rd(m0_addr) : 32'h0;
      end else if (srv == 2) begin
        e_rd = m1_rd; e_wr = m1_wr; e_addr = m1_addr; e_wdata = m1_wdata;
        e_rd1 = m1_rd ? reg_rd(m1_addr) : 32'h0;
      end
      chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, mo == 1});
      chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, mo == 2});
      chk("m0_ack", {31'd0, m0_ack}, {31'd0, srv == 1});
      chk("m1_ack", {31'd0, m1_ack}, {31'd0, srv == 2});
      chk("p_rd", {31'd0, p_rd}, {31'd0, e_rd});
      chk("p_wr", {31'd0, p_wr}, {31'd0, e_wr});
      chk("p_addr", p_addr, e_addr);
      chk("p_wdata", p_wdata, e_wdata);
      chk("m0_rdata", m0_rdata, e_rd0);
      chk("m1_rdata", m1_rdata, e_rd1);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
  endtask

  initial begin
    int wr0, rx0, opp, gnt_at, prd_cyc, both_ack;
    bit seen0, done0, done1;
    logic [11:0] seq;

    reset = 1;
    idle();
    nxt(); nxt();

    // Parked M0 reads SWITCH with zero wait
    reset = 0;
    m0_req = 1; m0_rd = 1; m0_addr = ADDR_SWITCH;
    @(negedge clk);
    chk("park_ack", {31'd0, m0_ack}, 32'd1);
    chk("park_rdata", m0_rdata, 32'h0000_00A5);
    chk("park_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    nxt();
    idle();
    @(negedge clk);
    nxt();

    // Handover: M1 write to LED lands one cycle after its request
    wr0 = wr_count;
    m1_req = 1; m1_wr = 1; m1_addr = ADDR_LED; m1_wdata = 32'h3C;
    @(negedge clk);
    chk("ho_ackN", {31'd0, m1_ack}, 32'd0);
    chk("ho_pwrN", {31'd0, p_wr}, 32'd0);
    nxt();
    @(negedge clk);
    chk("ho_gntN1", {31'd0, m1_gnt}, 32'd1);
    chk("ho_ackN1", {31'd0, m1_ack}, 32'd1);
    chk("ho_pwrN1", {31'd0, p_wr}, 32'd1);
    nxt();
    idle();
    @(negedge clk);
    chk("ho_led", regs[3], 32'h3C);
    chk("ho_wrcnt", wr_count - wr0, 32'd1);
    nxt();

    // Round-robin, both unlocked: acks alternate M0,M1,... (code 1=M0, 2=M1)
    seq = '0;
    m0_req = 1; m0_rd = 1; m0_addr = ADDR_TH;
    m1_req = 1; m1_rd = 1; m1_addr = ADDR_TH;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq = {seq[9:0], m1_ack, m0_ack};
      nxt();
    end
    chk("rr_seq", {20'd0, seq}, 32'h666);
    idle();
    @(negedge clk);
    nxt();

    // Bounded lock: M1 locked, M0 requests from the 2nd owned cycle
    m1_req = 1; m1_lock = 1; m1_rd = 1; m1_addr = ADDR_TL;
    @(negedge clk);
    nxt();
    opp = 0; gnt_at = 0; seen0 = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) begin m0_req = 1; m0_rd = 1; m0_addr = ADDR_TL; end
      @(negedge clk);
      if (!seen0 && m0_gnt) begin seen0 = 1; gnt_at = i; end
      if (!seen0 && i >= 2 && m1_ack) opp++;
      nxt();
    end
    chk("lock_opp_acks", opp, MAX_HOLD);
    chk("lock_m0_gnt_cyc", gnt_at, 6);
    idle();
    @(negedge clk);
    nxt();

    // Read-once: both read RXD; each drops its request once acked
    rx0 = rxd_reads; prd_cyc = 0; both_ack = 0; done0 = 0; done1 = 0;
    m0_rd = 1; m0_addr = ADDR_UART_RXD; m1_rd = 1; m1_addr = ADDR_UART_RXD;
    for (int i = 0; i < 8; i++) begin
      m0_req = !done0; m1_req = !done1;
      @(negedge clk);
      if (p_rd) prd_cyc++;
      if (m0_ack && m1_ack) both_ack++;
      if (m0_ack) done0 = 1;
      if (m1_ack) done1 = 1;
      nxt();
    end
    chk("rxd_reads", rxd_reads - rx0, 32'd2);
    chk("rxd_prd_cycles", prd_cyc, 32'd2);
    chk("rxd_both_ack", both_ack, 32'd0);
    chk("rxd_done", {30'd0, done1, done0}, 32'd3);
    idle();
    @(negedge clk);
    nxt();

    // Reset mid-burst with M1 locked at hold count 2
    m1_req = 1; m1_lock = 1; m1_rd = 1; m1_addr = ADDR_TCON;
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    m0_req = 1; m0_rd = 1; m0_addr = ADDR_TCON;
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    reset = 1;
    @(negedge clk);
    chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_p_rd", {31'd0, p_rd}, 32'd0);
    chk("rst_p_wr", {31'd0, p_wr}, 32'd0);
    nxt();
    reset = 0;
    @(negedge clk);
    chk("post_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("post_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("post_m0_ack", {31'd0, m0_ack}, 32'd1);
    nxt();
    @(negedge clk);
    chk("post_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("post_m0_ack2", {31'd0, m0_ack}, 32'd0);
    nxt();

    // Random traffic, occasional resets
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 3) != 0);
      m0_lock = $urandom_range(0, 1);
      m1_lock = ($urandom_range(0, 3) != 0);
      m0_rd   = $urandom_range(0, 1);
      m0_wr   = !m0_rd;
      m1_rd   = $urandom_range(0, 1);
      m1_wr   = !m1_rd;
      m0_addr = ADDR_TH + 32'($urandom_range(0, 8) * 4);
      m1_addr = ADDR_TH + 32'($urandom_range(0, 8) * 4);
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      nxt();
    end
    reset = 0;
    idle();
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
